// File: rtl/booth4_seq_mult_if.sv
// Operand/result handshake bundle for booth4_seq_mult.
// The master side supplies operands and consumes the product; the slave side is the multiplier.
interface booth4_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A_NUM;
  logic [WIDTH-1:0]     B_NUM;
  logic                 SIGNED_MODE;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   PRODUCT;

  modport master (
    output in_valid, A_NUM, B_NUM, SIGNED_MODE, out_ready,
    input  in_ready, out_valid, PRODUCT
  );

  modport slave (
    input  in_valid, A_NUM, B_NUM, SIGNED_MODE, out_ready,
    output in_ready, out_valid, PRODUCT
  );
endinterface

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit of A_NUM per clock, signed or unsigned per operation.
// Optional macro EARLY_TERM_EN stops the digit walk once the remaining multiplier bits are all equal.
module booth4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  booth4_seq_mult_if.slave      bus,
  output logic                  busy
);
  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int EW     = WIDTH + 2;
  localparam int AW     = 2 * EW;
  localparam int PW     = 2 * WIDTH;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW:0]     a_q, a_d;       // multiplier window, bit 0 is the implicit zero below a[0]
  logic [AW-1:0]   b_q, b_d;       // multiplicand, pre-shifted by 2*counter
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   term_s;
  logic [EW-1:0]   a_ext_s;
  logic [AW-1:0]   b_ext_s;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.PRODUCT   = product_q;
  assign busy          = busy_q;

  // Booth digit for the current window, expressed as a signed multiple of the multiplicand
  always_comb begin
    term_s = '0;
    case (a_q[2:0])
      3'b001, 3'b010: term_s = b_q;
      3'b011:         term_s = {b_q[AW-2:0], 1'b0};
      3'b100:         term_s = '0 - {b_q[AW-2:0], 1'b0};
      3'b101, 3'b110: term_s = '0 - b_q;
      default:        term_s = '0;
    endcase
  end

  always_comb begin
    a_ext_s = {{2{bus.A_NUM[WIDTH-1] & bus.SIGNED_MODE}}, bus.A_NUM};
    b_ext_s = {{(AW-WIDTH){bus.B_NUM[WIDTH-1] & bus.SIGNED_MODE}}, bus.B_NUM};
  end

`ifdef EARLY_TERM_EN
  logic rest_same_s;
  // After this digit, the bits still to be recoded start at a_q[2]; arithmetic shifting keeps the top replicated
  always_comb begin
    rest_same_s = (&a_q[EW:2]) | ~(|a_q[EW:2]);
  end
`endif

  // Next-state and next-output computation for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = S_CALC;
          a_d        = {a_ext_s, 1'b0};
          b_d        = b_ext_s;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CALC: begin
        // Counter reaching DIGITS marks the extra cycle that publishes the sum
        if (cnt_q == DIGITS_C) begin
          state_d     = S_DONE;
          product_d   = acc_q[PW-1:0];
          out_valid_d = 1'b1;
        end else begin
          acc_d = acc_q + term_s;
          a_d   = {{2{a_q[EW]}}, a_q[EW:2]};
          b_d   = {b_q[AW-3:0], 2'b00};
`ifdef EARLY_TERM_EN
          if (rest_same_s) begin
            cnt_d = DIGITS_C;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed-vector bench for booth4_seq_mult (WIDTH=16): products, latency, backpressure, reset.
module tb_booth4_seq_mult;
  localparam int W = 16;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  booth4_seq_mult_if #(.WIDTH(W)) bus ();

  booth4_seq_mult #(.WIDTH(W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Drives one operation, waits for out_valid, returns product and edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic release_out, output logic [2*W-1:0] prod, output int lat);
    @(negedge sys_clk);
    bus.in_valid    = 1'b1;
    bus.A_NUM       = a;
    bus.B_NUM       = b;
    bus.SIGNED_MODE = sgn;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.in_valid    = 1'b0;
    bus.A_NUM       = ~a;
    bus.B_NUM       = b ^ 16'h5A5A;
    bus.SIGNED_MODE = ~sgn;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid not seen within %0d edges", lat);
    end
    prod = bus.PRODUCT;
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [2*W-1:0] prod;
    int lat;

    vecs[0]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[3]  = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1};
    vecs[4]  = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000};
    vecs[5]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vecs[6]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000_000F};
    vecs[7]  = '{16'h0000, 16'h1234, 1'b1, 32'h0000_0000};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
    vecs[9]  = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE};
    vecs[10] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE};
    vecs[11] = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060};

    sys_rst         = 1'b1;
    bus.in_valid    = 1'b0;
    bus.A_NUM       = 16'h0000;
    bus.B_NUM       = 16'h0000;
    bus.SIGNED_MODE = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_product",   64'(bus.PRODUCT),   64'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b1, prod, lat);
      check($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].exp));
`ifndef EARLY_TERM_EN
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
`endif
      check($sformatf("vec%0d_in_ready_after", i), 64'(bus.in_ready), 64'd1);
    end

    // Backpressure: hold DONE for 20 cycles while offering new operands
    run_op(16'h0007, 16'h0009, 1'b0, 1'b0, prod, lat);
    check("bp_product", 64'(prod), 64'd63);
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.A_NUM    = 16'(c + 100);
      bus.B_NUM    = 16'h0011;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check($sformatf("bp_hold%0d", c),
            {31'd0, bus.out_valid, bus.in_ready, busy, bus.PRODUCT},
            {31'd0, 1'b1, 1'b0, 1'b1, 32'd63});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.out_ready = 1'b0;
    check("bp_release", {61'd0, bus.in_ready, bus.out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("bp_not_queued", {31'd0, busy, bus.PRODUCT}, {31'd0, 1'b0, 32'd63});

    // Reset during the fourth CALC cycle
    @(negedge sys_clk);
    bus.in_valid    = 1'b1;
    bus.A_NUM       = 16'h1234;
    bus.B_NUM       = 16'h4321;
    bus.SIGNED_MODE = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_outputs",
          {29'd0, bus.in_ready, bus.out_valid, busy, bus.PRODUCT},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    repeat (12) @(posedge sys_clk);
    @(negedge sys_clk);
    check("midrst_no_result", {63'd0, bus.out_valid}, 64'd0);
    run_op(16'h0002, 16'h0003, 1'b0, 1'b1, prod, lat);
    check("midrst_after_op", 64'(prod), 64'd6);

    // Random pairs against an arithmetic reference
    for (int r = 0; r < 200; r++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      longint       sa, sb;
      logic [63:0]  full;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(1));
      sa = rs ? longint'($signed(ra)) : longint'(ra);
      sb = rs ? longint'($signed(rb)) : longint'(rb);
      full = 64'(sa * sb);
      run_op(ra, rb, rs, 1'b1, prod, lat);
      check($sformatf("rand%0d_a%h_b%h_s%0d", r, ra, rb, rs), 64'(prod), {32'd0, full[31:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
